// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module  : mem_bus_arbiter
// Brief   : Two-master round-robin arbiter with lockable bursts onto one memory port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic        wr_ena0,
  input  logic        wr_ena1,
  input  logic [31:0] wr_data0,
  input  logic [31:0] wr_data1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rd_data0,
  output logic [31:0] rd_data1,
  output logic [1:0]  gnt,
  output logic [31:0] mem_addr,
  output logic        mem_wr_ena,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data
);

  localparam logic [3:0] c_MAX_BURST = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_gnt;
  logic       r_last;
  logic [3:0] r_count;

  logic w_any;
  logic w_win;
  logic w_cur_req;
  logic w_cur_lock;
  logic w_cont;
  logic w_access;
  logic w_resp;

  // w_win = 1 selects master 1; on a tie the master not granted last wins.
  assign w_any      = req0 | req1;
  assign w_win      = (req0 & req1) ? ~r_last : req1;
  assign w_cur_req  = r_gnt[1] ? req1  : req0;
  assign w_cur_lock = r_gnt[1] ? lock1 : lock0;
  assign w_cont     = w_cur_req & w_cur_lock & (r_count < c_MAX_BURST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_gnt   <= 2'b00;
      r_last  <= 1'b1;
      r_count <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= ACCESS;
            r_gnt   <= w_win ? 2'b10 : 2'b01;
            r_last  <= w_win;
            r_count <= 4'd1;
          end else begin
            r_gnt   <= 2'b00;
            r_count <= 4'd0;
          end
        end
        ACCESS: r_state <= RESP;
        RESP: begin
          if (w_cont) begin
            r_state <= ACCESS;
            r_count <= r_count + 4'd1;
          end else if (w_any) begin
            r_state <= ACCESS;
            r_gnt   <= w_win ? 2'b10 : 2'b01;
            r_last  <= w_win;
            r_count <= 4'd1;
          end else begin
            r_state <= IDLE;
            r_gnt   <= 2'b00;
            r_count <= 4'd0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 2'b00;
          r_count <= 4'd0;
        end
      endcase
    end
  end

  assign w_access = (r_state == ACCESS);
  assign w_resp   = (r_state == RESP);

  // Memory port is driven only during ACCESS so the write strobe is a single cycle.
  assign gnt         = r_gnt;
  assign mem_addr    = w_access ? (r_gnt[1] ? addr1    : addr0)    : 32'd0;
  assign mem_wr_data = w_access ? (r_gnt[1] ? wr_data1 : wr_data0) : 32'd0;
  assign mem_wr_ena  = w_access & (r_gnt[1] ? wr_ena1 : wr_ena0);

  assign ack0     = w_resp & r_gnt[0];
  assign ack1     = w_resp & r_gnt[1];
  assign rd_data0 = ack0 ? mem_rd_data : 32'd0;
  assign rd_data1 = ack1 ? mem_rd_data : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module  : tb_mem_bus_arbiter
// Brief   : Directed vector-table bench for mem_bus_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

  localparam logic [31:0] c_A0 = 32'h0000_0010;
  localparam logic [31:0] c_A1 = 32'h0000_0020;
  localparam logic [31:0] c_D0 = 32'hA0A0_A0A0;
  localparam logic [31:0] c_D1 = 32'h0000_0055;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, lock0, lock1;
  logic [31:0] addr0, addr1;
  logic        wr_ena0, wr_ena1;
  logic [31:0] wr_data0, wr_data1;
  logic        ack0, ack1;
  logic [31:0] rd_data0, rd_data1;
  logic [1:0]  gnt;
  logic [31:0] mem_addr;
  logic        mem_wr_ena;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1),
    .wr_ena0(wr_ena0), .wr_ena1(wr_ena1),
    .wr_data0(wr_data0), .wr_data1(wr_data1),
    .ack0(ack0), .ack1(ack1),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .gnt(gnt),
    .mem_addr(mem_addr), .mem_wr_ena(mem_wr_ena), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  // Packed output bundle: {gnt, ack1, ack0, rd_data0, rd_data1, mem_addr, mem_wr_ena, mem_wr_data}
  typedef struct {
    logic         rst;
    logic [1:0]   req;
    logic [1:0]   lock;
    logic [1:0]   we;
    logic [31:0]  mrd;
    logic [132:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [132:0] e_idle();
    return '0;
  endfunction

  function automatic logic [132:0] e_acc(input logic m, input logic we);
    return {(m ? 2'b10 : 2'b01), 2'b00, 32'd0, 32'd0, (m ? c_A1 : c_A0), we, (m ? c_D1 : c_D0)};
  endfunction

  function automatic logic [132:0] e_resp(input logic m, input logic [31:0] mrd);
    return {(m ? 2'b10 : 2'b01), (m ? 2'b10 : 2'b01), (m ? 32'd0 : mrd), (m ? mrd : 32'd0),
            32'd0, 1'b0, 32'd0};
  endfunction

  function automatic logic [132:0] actual();
    return {gnt, ack1, ack0, rd_data0, rd_data1, mem_addr, mem_wr_ena, mem_wr_data};
  endfunction

  task automatic add(input logic r, input logic [1:0] rq, input logic [1:0] lk,
                     input logic [1:0] we, input logic [31:0] mrd, input logic [132:0] ex);
    vec_t v;
    v.rst = r; v.req = rq; v.lock = lk; v.we = we; v.mrd = mrd; v.exp = ex;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_ack1;

  initial begin
    rst = 1'b0; req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    addr0 = c_A0; addr1 = c_A1; wr_data0 = c_D0; wr_data1 = c_D1;
    wr_ena0 = 0; wr_ena1 = 0; mem_rd_data = 32'h0;

    // reset
    add(0, 2'b00, 2'b00, 2'b00, 32'h0, e_idle());
    add(0, 2'b11, 2'b11, 2'b11, 32'h0, e_idle());
    // single read by master 0
    add(1, 2'b01, 2'b00, 2'b00, 32'hDEADBEEF, e_acc(0, 0));
    add(1, 2'b01, 2'b00, 2'b00, 32'hDEADBEEF, e_resp(0, 32'hDEADBEEF));
    add(1, 2'b00, 2'b00, 2'b00, 32'h0, e_idle());
    add(1, 2'b00, 2'b00, 2'b00, 32'h0, e_idle());
    // single write by master 1
    add(1, 2'b10, 2'b00, 2'b10, 32'h0, e_acc(1, 1));
    add(1, 2'b10, 2'b00, 2'b10, 32'h1234, e_resp(1, 32'h1234));
    add(1, 2'b00, 2'b00, 2'b00, 32'h0, e_idle());
    // tie, no lock: alternate 0,1,0,1
    add(1, 2'b11, 2'b00, 2'b00, 32'hCAFE, e_acc(0, 0));
    add(1, 2'b11, 2'b00, 2'b00, 32'hCAFE, e_resp(0, 32'hCAFE));
    add(1, 2'b11, 2'b00, 2'b00, 32'hCAFE, e_acc(1, 0));
    add(1, 2'b11, 2'b00, 2'b00, 32'hCAFE, e_resp(1, 32'hCAFE));
    add(1, 2'b11, 2'b00, 2'b00, 32'hBEEF, e_acc(0, 0));
    add(1, 2'b11, 2'b00, 2'b00, 32'hBEEF, e_resp(0, 32'hBEEF));
    add(1, 2'b11, 2'b00, 2'b00, 32'hBEEF, e_acc(1, 0));
    add(1, 2'b11, 2'b00, 2'b00, 32'hBEEF, e_resp(1, 32'hBEEF));
    add(1, 2'b00, 2'b00, 2'b00, 32'h0, e_idle());
    // locked burst on master 0 with master 1 waiting; lock1 must not matter
    for (int b = 0; b < 4; b++) begin
      add(1, 2'b11, 2'b11, 2'b00, 32'h100 + b, e_acc(0, 0));
      add(1, 2'b11, 2'b11, 2'b00, 32'h100 + b, e_resp(0, 32'h100 + b));
    end
    add(1, 2'b11, 2'b11, 2'b00, 32'h777, e_acc(1, 0));
    add(1, 2'b11, 2'b01, 2'b00, 32'h777, e_resp(1, 32'h777));
    add(1, 2'b00, 2'b00, 2'b00, 32'h0, e_idle());

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      {req1, req0}       = vecs[i].req;
      {lock1, lock0}     = vecs[i].lock;
      {wr_ena1, wr_ena0} = vecs[i].we;
      mem_rd_data        = vecs[i].mrd;
      tick();
      n_checks++;
      if (actual() === vecs[i].exp) n_pass++;
      else $display("FAIL vec[%0d] got=%h exp=%h", i, actual(), vecs[i].exp);
    end

    // req0 dropped during ACCESS still completes once, then idles
    lock0 = 0; lock1 = 0; mem_rd_data = 32'h600D;
    req0 = 1;
    tick();
    chk("drop_access_gnt", {30'd0, gnt}, 32'd1);
    req0 = 0;
    tick();
    chk("drop_ack0", {30'd0, ack1, ack0}, 32'd1);
    chk("drop_rd0", rd_data0, 32'h600D);
    tick();
    chk("drop_idle_gnt", {30'd0, gnt}, 32'd0);
    chk("drop_no_reack", {30'd0, ack1, ack0}, 32'd0);

    // reset asserted mid-ACCESS of a write aborts at once
    req1 = 1; wr_ena1 = 1; mem_rd_data = 32'h0;
    tick();
    chk("wr_access_we", {31'd0, mem_wr_ena}, 32'd1);
    chk("wr_access_addr", mem_addr, c_A1);
    #2 rst = 0;
    #1;
    chk("rst_abort_we", {31'd0, mem_wr_ena}, 32'd0);
    chk("rst_abort_gnt", {30'd0, gnt}, 32'd0);
    tick();
    chk("rst_abort_noack", {30'd0, ack1, ack0}, 32'd0);
    rst = 1;
    n_ack1 = 0;
    tick();
    chk("rst_rearb_gnt", {30'd0, gnt}, 32'd2);
    chk("rst_rearb_we", {31'd0, mem_wr_ena}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ack1) begin
        n_ack1++;
        req1 = 0;
        wr_ena1 = 0;
      end
    end
    chk("rst_rearb_one_ack", n_ack1, 32'd1);
    chk("rst_rearb_idle_gnt", {30'd0, gnt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4: maximum consecutive grants to one locked master (legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have ports req0/req1  input  1  master 0 (core) / master 1 (loader/DMA) transaction request.
REQ-005 SHALL have ports lock0/lock1  input  1  master requests burst retention of the grant.
REQ-006 SHALL have ports addr0/addr1  input  32  master byte address.
REQ-007 SHALL have ports wr_ena0/wr_ena1  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports wr_data0/wr_data1  input  32  master write data.
REQ-009 SHALL have ports ack0/ack1  output  1  one-cycle transaction-complete strobe.
REQ-010 SHALL have ports rd_data0/rd_data1  output  32  read data, valid with ack.
REQ-011 SHALL have port gnt  output  2  one-hot registered grant, bit i = master i.
REQ-012 SHALL have ports mem_addr / mem_wr_ena / mem_wr_data  output  32/1/32  shared MMU port.
REQ-013 SHALL have port mem_rd_data  input  32  MMU read data, one cycle after address.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, RESP, one-hot or binary encoded.
REQ-015 IDLE: if any req, pick winner and go to ACCESS, gnt <= winner; else stay IDLE, gnt = 00.
REQ-016 Arbitration SHALL be round-robin: single req wins; both req -> master not granted last wins; last-grant pointer resets to 1, so master 0 wins first tie.
REQ-017 ACCESS (1 cycle): mem_addr/mem_wr_data/mem_wr_ena SHALL combinationally follow granted master; next state RESP.
REQ-018 Outside ACCESS mem_wr_ena SHALL be 0, mem_addr and mem_wr_data 0; exactly one write pulse per write transaction.
REQ-019 RESP (1 cycle): ack of granted master = 1, its rd_data = mem_rd_data; other ack 0, all non-acked rd_data 0.
REQ-020 Write transactions SHALL also ack in RESP; rd_data during write ack equals mem_rd_data (don't-care to master).
REQ-021 From RESP: if granted master has req=1, lock=1 and beat count < MAX_BURST -> ACCESS, same master, count+1, pointer unchanged.
REQ-022 From RESP otherwise: arbitrate as REQ-016 against current req inputs -> ACCESS with winner (count = 1), or IDLE if no req.
REQ-023 Beat count (4 bits) SHALL be 1 on first grant, saturate conceptually at MAX_BURST; reaching it forces re-arbitration even if lock held.
REQ-024 Throughput SHALL be one transaction per 2 cycles; request-to-ack latency 2 cycles from IDLE (req at edge N -> ack high cycle N+2).
REQ-025 Masters SHALL hold addr/wr_ena/wr_data/req stable until ack; arbiter captures nothing.
REQ-026 req dropped during ACCESS: transaction still completes and acks; dropped in RESP: no further grant.
REQ-027 lock on the non-granted master SHALL have no effect on arbitration.
REQ-028 gnt SHALL change only on the RESP->ACCESS or IDLE->ACCESS edge, and clear on RESP->IDLE.

Reset
REQ-029 While rst=0: state IDLE, gnt=00, ack0=ack1=0, rd_data0/1=0, mem_* outputs 0, beat count 0, pointer=1.
REQ-030 Reset asserted in ACCESS or RESP SHALL abort immediately: no ack, no mem_wr_ena; after release, pending req re-arbitrated from IDLE.

Verification
REQ-031 Single read: req0=1, addr0=0x10, mem_rd_data=0xDEADBEEF -> mem_addr=0x10 cycle 1, ack0=1 with rd_data0=0xDEADBEEF cycle 2, ack1=0.
REQ-032 Tie: req0=req1=1 held, lock=0, after reset -> grants alternate 0,1,0,1; each ack every 4 cycles.
REQ-033 Burst: req0=lock0=1, req1=1, MAX_BURST=4 -> four consecutive master-0 acks, then master 1 granted.
REQ-034 Write: req1=1, wr_ena1=1, addr1=0x20, wr_data1=0x55 -> mem_wr_ena high exactly 1 cycle with mem_addr=0x20, mem_wr_data=0x55, ack1 next cycle.
REQ-035 Reset mid-ACCESS of a write: rst=0 during ACCESS -> mem_wr_ena=0 and gnt=00 same cycle, no ack; release with req held -> fresh transaction, one ack.
REQ-036 Drop: req0 deasserted during ACCESS -> ack0 still pulses once in RESP, then IDLE, gnt=00.
